// File: rtl/adc_spi_pkg.sv
// ---------------------------------------------------------------------------
// adc_spi_pkg
//   Shared definitions for the ADC-side SPI responder: frame geometry, the
//   layout of the 12-bit control word, the responder FSM states and the
//   sample-to-two's-complement helper.
// ---------------------------------------------------------------------------
package adc_spi_pkg;

  // Frame geometry: 16 SCLK rising edges carry {0, ADD2..ADD0, D11..D0} out
  // and a 12-bit control word (plus 4 trailing don't-care bits) in.
  localparam int DATA_BITS  = 12;
  localparam int NUM_CH     = 8;
  localparam int ADDR_BITS  = $clog2(NUM_CH);
  localparam int FRAME_BITS = 16;
  localparam int CTRL_BITS  = 12;

  // Control word as committed from rxShift[15:4]. Field order fixes the bit
  // indices: WRITE=11, SEQ=10, ADD2..0=8:6, PM1/0=5:4, SHADOW=3, RANGE=1,
  // CODING=0. Bits 9 and 2 are don't-care positions in the frame.
  typedef struct packed {
    logic                 write;   // 11
    logic                 seq;     // 10
    logic                 dc9;     // 9
    logic [ADDR_BITS-1:0] add;     // 8:6
    logic [1:0]           pm;      // 5:4
    logic                 shadow;  // 3
    logic                 dc2;     // 2
    logic                 range;   // 1
    logic                 coding;  // 0
  } ctrl_word_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Straight binary -> two's complement around mid-scale: invert the MSB.
  function automatic logic [DATA_BITS-1:0] to_twos(input logic [DATA_BITS-1:0] sample);
    return {~sample[DATA_BITS-1], sample[DATA_BITS-2:0]};
  endfunction

endpackage : adc_spi_pkg

// File: rtl/adc_spi_if.sv
// ---------------------------------------------------------------------------
// adc_spi_if
//   The four SPI wires between a capture-side master and the ADC-side
//   responder.
//     SCLK  serial clock, driven by the master
//     CSN   chip select, active low, driven by the master
//     DIN   control data master -> responder, sampled on SCLK rise
//     DOUT  conversion data responder -> master, changed on SCLK fall
//   Modports: master (drives SCLK/CSN/DIN), slave (drives DOUT).
// ---------------------------------------------------------------------------
interface adc_spi_if;

  logic SCLK;
  logic CSN;
  logic DIN;
  logic DOUT;

  modport master (
    output SCLK,
    output CSN,
    output DIN,
    input  DOUT
  );

  modport slave (
    input  SCLK,
    input  CSN,
    input  DIN,
    output DOUT
  );

endinterface : adc_spi_if

// File: rtl/spi_input_sync.sv
// ---------------------------------------------------------------------------
// spi_input_sync
//   Brings one asynchronous SPI wire into the clk domain through a STAGES-deep
//   flop chain and reports single-cycle rise/fall pulses.
//   Ports:
//     clk       system clock
//     rst       asynchronous, active-high reset
//     async_in  wire from the pads (asynchronous to clk)
//     sync_out  synchronized level (last synchronizer stage)
//     rise      1-cycle pulse when sync_out goes 0 -> 1
//     fall      1-cycle pulse when sync_out goes 1 -> 0
//   Parameters:
//     STAGES    synchronizer depth (>= 2)
//     RST_VAL   idle level of the wire, loaded on reset so that leaving
//               reset with the wire idle creates no edge
// ---------------------------------------------------------------------------
module spi_input_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  // chain[STAGES-1:0] is the synchronizer proper; chain[STAGES] holds the
  // previous synchronized value so edges come from the last two stages and
  // never look at a possibly metastable flop.
  logic [STAGES:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the chain into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {(STAGES + 1){RST_VAL}};
    end else begin
      chain <= {chain[STAGES-1:0], async_in};
    end
  end

  assign sync_out = chain[STAGES-1];
  assign rise     =  chain[STAGES-1] & ~chain[STAGES];
  assign fall     = ~chain[STAGES-1] &  chain[STAGES];

endmodule : spi_input_sync

// File: rtl/adc_spi_responder.sv
// ---------------------------------------------------------------------------
// adc_spi_responder
//   ADC-side SPI responder for the 8-channel / 12-bit frame unpacked by the
//   SPI capture path. SCLK, CSN and DIN are oversampled in the CLOCK_50
//   domain; each frame shifts a 16-bit control word in and drives
//   {0, ADD2..ADD0, D11..D0} out MSB first.
//   Used as an on-FPGA loopback target and as the DUT-side model in
//   capture-block benches.
//
//   Ports:
//     CLOCK_50    system clock, the only clock in the block
//     reset       asynchronous, active-high reset
//     spi         SPI wires (slave modport): SCLK, CSN, DIN in; DOUT out
//     sampleData  NUM_CH x DATA_BITS straight-binary samples, ch n at
//                 [12n+11:12n]
//     ctrlWord    last committed control word
//     curAddr     channel returned in the next frame
//     busy        high while synchronized CSN is low
//     frameDone   1-cycle pulse: frame closed after exactly 16 rising edges
//     frameErr    1-cycle pulse: frame closed after 1..15 rising edges
//
//   Each SCLK phase must last at least SYNC_STAGES+2 CLOCK_50 cycles.
//   Data returned in frame N is the channel committed by frame N-1; the
//   sample is captured at the CSN fall that opens the frame.
// ---------------------------------------------------------------------------
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  adc_spi_if.slave                      spi,
  input  logic [NUM_CH*DATA_BITS-1:0]   sampleData,
  output logic [CTRL_BITS-1:0]          ctrlWord,
  output logic [ADDR_BITS-1:0]          curAddr,
  output logic                          busy,
  output logic                          frameDone,
  output logic                          frameErr
);

  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

  // -------------------------------------------------------------------------
  // Input synchronizers
  // -------------------------------------------------------------------------
  logic sclk_sync, sclk_rise, sclk_fall;
  logic csn_sync,  csn_rise,  csn_fall;
  logic din_sync,  din_rise,  din_fall;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk      (CLOCK_50),
    .rst      (reset),
    .async_in (spi.SCLK),
    .sync_out (sclk_sync),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  // CSN idles high; resetting its chain high keeps busy low through reset.
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
    .clk      (CLOCK_50),
    .rst      (reset),
    .async_in (spi.CSN),
    .sync_out (csn_sync),
    .rise     (csn_rise),
    .fall     (csn_fall)
  );

  // DIN goes through the same depth as SCLK, so at an SCLK rise pulse
  // din_sync is the level that was on the wire at that rising edge.
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din_sync (
    .clk      (CLOCK_50),
    .rst      (reset),
    .async_in (spi.DIN),
    .sync_out (din_sync),
    .rise     (din_rise),
    .fall     (din_fall)
  );

  // -------------------------------------------------------------------------
  // State and registers
  // -------------------------------------------------------------------------
  state_t                  state, state_next;
  logic [4:0]              bit_cnt;
  logic [FRAME_BITS-1:0]   rx_shift;
  logic [FRAME_BITS-1:0]   tx_shift;
  logic                    dout_q;
  ctrl_word_t              ctrl_q;
  logic                    frame_done_q, frame_err_q;

  // curAddr, codingBit and rangeBit always equal their fields of the
  // committed control word, so they are views of ctrl_q rather than copies.
  logic [ADDR_BITS-1:0]    cur_addr;
  logic                    coding_bit;
  logic                    range_bit;

  assign cur_addr   = ctrl_q.add;
  assign coding_bit = ctrl_q.coding;
  assign range_bit  = ctrl_q.range;

  // Frame to transmit if CSN falls now.
  logic [DATA_BITS-1:0]    cur_sample;
  logic [FRAME_BITS-1:0]   tx_frame;

  assign cur_sample = sampleData[cur_addr*DATA_BITS +: DATA_BITS];
  assign tx_frame   = {1'b0, cur_addr, (coding_bit ? cur_sample : to_twos(cur_sample))};

  // Received control word, valid once 16 bits are in.
  ctrl_word_t              rx_ctrl;
  assign rx_ctrl = ctrl_word_t'(rx_shift[FRAME_BITS-1:FRAME_BITS-CTRL_BITS]);

  // -------------------------------------------------------------------------
  // FSM: next state and per-cycle strobes
  // -------------------------------------------------------------------------
  logic load_tx;     // CSN fell: capture sample, present first bit
  logic rx_shift_en; // SCLK rose inside the frame: take a DIN bit
  logic tx_shift_en; // SCLK fell after bit 1..15: present the next bit
  logic tx_clear;    // SCLK fell past the frame: trailing clocks read 0
  logic end_frame;   // CSN rose: close the frame
  logic frame_done_d, frame_err_d, commit;

  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    state_next  = state;
    load_tx     = 1'b0;
    rx_shift_en = 1'b0;
    tx_shift_en = 1'b0;
    tx_clear    = 1'b0;
    end_frame   = 1'b0;

    unique case (state)
      IDLE: begin
        // SCLK edges are ignored while idle.
        if (csn_fall) begin
          state_next = SHIFT;
          load_tx    = 1'b1;
        end
      end
      SHIFT: begin
        // A CSN rise wins over an SCLK edge detected in the same cycle.
        if (csn_rise) begin
          state_next = IDLE;
          end_frame  = 1'b1;
        end else begin
          if (sclk_rise && (bit_cnt < FRAME_CNT)) begin
            rx_shift_en = 1'b1;
          end
          if (sclk_fall) begin
            if ((bit_cnt != 5'd0) && (bit_cnt < FRAME_CNT)) begin
              tx_shift_en = 1'b1;
            end else if (bit_cnt >= FRAME_CNT) begin
              tx_clear = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Closing a frame with zero rising edges is silent; a short frame is an
  // error; only a complete frame may commit, and only if WRITE is set.
  assign frame_done_d = end_frame && (bit_cnt == FRAME_CNT);
  assign frame_err_d  = end_frame && (bit_cnt != 5'd0) && (bit_cnt < FRAME_CNT);
  assign commit       = frame_done_d && rx_ctrl.write;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      dout_q       <= 1'b0;
      ctrl_q       <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;

      if (load_tx) begin
        tx_shift <= tx_frame;
        dout_q   <= tx_frame[FRAME_BITS-1];
        rx_shift <= '0;
        bit_cnt  <= '0;
      end else if (rx_shift_en) begin
        rx_shift <= {rx_shift[FRAME_BITS-2:0], din_sync};
        bit_cnt  <= bit_cnt + 5'd1;
      end else if (tx_shift_en) begin
        // Bit 15 went out at the CSN fall; falls 1..15 present bits 14..0.
        tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
        dout_q   <= tx_shift[FRAME_BITS-2];
      end else if (tx_clear) begin
        dout_q <= 1'b0;
      end else if (end_frame) begin
        dout_q  <= 1'b0;
        bit_cnt <= '0;
        if (commit) begin
          ctrl_q <= rx_ctrl;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign spi.DOUT  = dout_q;
  assign ctrlWord  = ctrl_q;
  assign curAddr   = cur_addr;
  assign busy      = ~csn_sync;
  assign frameDone = frame_done_q;
  assign frameErr  = frame_err_q;

  // RANGE is held but has no effect on data; the low four frame bits, the
  // SCLK level and DIN edges are never needed.
  logic unused_ok;
  assign unused_ok = ^{rx_shift[FRAME_BITS-CTRL_BITS-1:0], range_bit,
                       sclk_sync, din_rise, din_fall};

endmodule : adc_spi_responder

// File: tb/tb_adc_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_responder
//   Drives SPI frames into adc_spi_responder and compares DOUT, the pulses
//   and the committed control word with a reference model of the frame
//   rules (channel pipeline, coding, WRITE gating, short-frame abort).
// ---------------------------------------------------------------------------
module tb_adc_spi_responder;
  import adc_spi_pkg::*;

  localparam int HALF = 10;  // CLOCK_50 cycles per SCLK phase

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic [95:0] sampleData;
  logic [11:0] ctrlWord;
  logic [2:0]  curAddr;
  logic        busy, frameDone, frameErr;

  adc_spi_if spi();

  adc_spi_responder #(.SYNC_STAGES(2)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .spi        (spi),
    .sampleData (sampleData),
    .ctrlWord   (ctrlWord),
    .curAddr    (curAddr),
    .busy       (busy),
    .frameDone  (frameDone),
    .frameErr   (frameErr)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // Pulse monitor: events = rising transitions, hi = cycles spent high.
  int   done_ev = 0, done_hi = 0, err_ev = 0, err_hi = 0;
  logic done_prev = 1'b0, err_prev = 1'b0;

  always @(negedge CLOCK_50) begin
    if (frameDone)              done_hi <= done_hi + 1;
    if (frameDone && !done_prev) done_ev <= done_ev + 1;
    if (frameErr)               err_hi  <= err_hi + 1;
    if (frameErr && !err_prev)  err_ev  <= err_ev + 1;
    done_prev <= frameDone;
    err_prev  <= frameErr;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  logic [11:0] m_ctrl;
  logic [2:0]  m_addr;
  logic        m_coding;

  // Frame the responder should send for channel addr under the given coding.
  function automatic logic [15:0] model_frame(input logic [95:0] bus, input int addr,
                                              input logic coding);
    logic [95:0] shifted;
    int          sample;
    shifted = bus >> (addr * 12);
    sample  = int'(shifted[11:0]);
    if (!coding) sample = (sample + 2048) % 4096;  // offset binary -> two's complement
    return 16'(addr * 4096 + sample);
  endfunction

  // Register update when a frame with n_rise rising edges is closed.
  task automatic model_end(input logic [15:0] din_word, input int n_rise);
    int w;
    w = int'(din_word);
    if (n_rise >= 16 && w >= 32768) begin
      m_ctrl   = 12'(w / 16);
      m_addr   = 3'((w / 1024) % 8);
      m_coding = 1'((w / 16) % 2);
    end
  endtask

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge CLOCK_50);
    #5;
  endtask

  // One frame: CSN low, n_rise SCLK pulses, CSN high. stream[17-i] is the
  // DOUT level seen just before rising edge i.
  task automatic do_frame(input logic [15:0] din_word, input int n_rise,
                          output logic [17:0] stream, output logic busy_seen,
                          output logic dout_after);
    stream = '0;
    spi.CSN = 1'b0;
    wait_clks(HALF);
    busy_seen = busy;
    for (int i = 0; i < n_rise; i++) begin
      spi.DIN = (i < 16) ? din_word[15-i] : 1'b0;
      wait_clks(HALF);
      if (i < 18) stream[17-i] = spi.DOUT;
      spi.SCLK = 1'b1;
      wait_clks(HALF);
      spi.SCLK = 1'b0;
    end
    wait_clks(HALF);
    spi.CSN = 1'b1;
    spi.DIN = 1'b0;
    wait_clks(HALF);
    dout_after = spi.DOUT;
  endtask

  // ------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    wait_clks(5);
    checks++; if (ctrlWord !== 12'h000) begin errors++; $display("FAIL reset_ctrlWord got %h want 000", ctrlWord); end
    checks++; if (curAddr !== 3'd0) begin errors++; $display("FAIL reset_curAddr got %0d want 0", curAddr); end
    checks++; if ({spi.DOUT, busy, frameDone, frameErr} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags dout/busy/done/err got %b want 0000", {spi.DOUT, busy, frameDone, frameErr});
    end
    reset = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic test_write_frame();
    logic [17:0] st; logic bs, da; logic [15:0] exp_f; int d0, h0, e0;
    sampleData = {$urandom, $urandom, $urandom};
    exp_f = model_frame(sampleData, m_addr, m_coding);
    d0 = done_ev; h0 = done_hi; e0 = err_ev;
    do_frame(16'h8C30, 16, st, bs, da);
    model_end(16'h8C30, 16);
    checks++; if (st[17:2] !== exp_f) begin errors++; $display("FAIL wr_dout got %h want %h", st[17:2], exp_f); end
    checks++; if (bs !== 1'b1) begin errors++; $display("FAIL wr_busy got %b want 1", bs); end
    checks++; if (done_ev - d0 !== 1 || done_hi - h0 !== 1) begin
      errors++; $display("FAIL wr_done events %0d cycles %0d want 1 1", done_ev - d0, done_hi - h0);
    end
    checks++; if (err_ev - e0 !== 0) begin errors++; $display("FAIL wr_err got %0d want 0", err_ev - e0); end
    checks++; if (ctrlWord !== 12'h8C3) begin errors++; $display("FAIL wr_ctrlWord got %h want 8C3", ctrlWord); end
    checks++; if (curAddr !== 3'd3) begin errors++; $display("FAIL wr_curAddr got %0d want 3", curAddr); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL wr_dout_idle got %b want 0", da); end
  endtask

  task automatic test_coding();
    logic [17:0] st; logic bs, da; logic [15:0] exp_f; int d0, h0;
    sampleData = {$urandom, $urandom, $urandom};
    sampleData[47:36] = 12'h5A5;
    // CODING=1 still in force: straight binary, 18 clocks, trailing zeros.
    exp_f = model_frame(sampleData, m_addr, m_coding);
    d0 = done_ev; h0 = done_hi;
    do_frame(16'h8C20, 18, st, bs, da);
    model_end(16'h8C20, 18);
    checks++; if (st[17:2] !== exp_f || st[17:2] !== 16'h35A5) begin
      errors++; $display("FAIL cod1_dout got %h want %h", st[17:2], exp_f);
    end
    checks++; if (st[1:0] !== 2'b00) begin errors++; $display("FAIL cod1_tail got %b want 00", st[1:0]); end
    checks++; if (done_ev - d0 !== 1 || done_hi - h0 !== 1) begin
      errors++; $display("FAIL cod1_done events %0d cycles %0d want 1 1", done_ev - d0, done_hi - h0);
    end
    // CODING=0 committed: MSB of the sample flips.
    exp_f = model_frame(sampleData, m_addr, m_coding);
    do_frame(16'h0000, 16, st, bs, da);
    model_end(16'h0000, 16);
    checks++; if (st[17:2] !== exp_f || st[17:2] !== 16'h3DA5) begin
      errors++; $display("FAIL cod0_dout got %h want %h", st[17:2], exp_f);
    end
    checks++; if (ctrlWord !== 12'h8C2) begin errors++; $display("FAIL cod0_ctrlWord got %h want 8C2", ctrlWord); end
  endtask

  task automatic test_no_write();
    logic [17:0] st; logic bs, da; int d0;
    d0 = done_ev;
    do_frame(16'h3FFF, 16, st, bs, da);
    model_end(16'h3FFF, 16);
    checks++; if (done_ev - d0 !== 1) begin errors++; $display("FAIL nowr_done got %0d want 1", done_ev - d0); end
    checks++; if (ctrlWord !== 12'h8C2 || curAddr !== 3'd3) begin
      errors++; $display("FAIL nowr_regs got %h/%0d want 8C2/3", ctrlWord, curAddr);
    end
  endtask

  task automatic test_abort();
    logic [17:0] st, exp_s, mask; logic bs, da; logic [15:0] din; int d0, e0, h0;
    sampleData = {$urandom, $urandom, $urandom};
    din = 16'($urandom) | 16'h8000;
    exp_s = {model_frame(sampleData, m_addr, m_coding), 2'b00};
    mask  = 18'h3FE00;  // first 9 bits observed
    d0 = done_ev; e0 = err_ev; h0 = err_hi;
    do_frame(din, 9, st, bs, da);
    model_end(din, 9);
    checks++; if ((st & mask) !== (exp_s & mask)) begin errors++; $display("FAIL abort_dout got %h want %h", st & mask, exp_s & mask); end
    checks++; if (err_ev - e0 !== 1 || err_hi - h0 !== 1) begin
      errors++; $display("FAIL abort_err events %0d cycles %0d want 1 1", err_ev - e0, err_hi - h0);
    end
    checks++; if (done_ev - d0 !== 0) begin errors++; $display("FAIL abort_done got %0d want 0", done_ev - d0); end
    checks++; if (ctrlWord !== m_ctrl) begin errors++; $display("FAIL abort_ctrlWord got %h want %h", ctrlWord, m_ctrl); end
    // Recovery frame.
    din = 16'($urandom) | 16'h8000;
    exp_s = {model_frame(sampleData, m_addr, m_coding), 2'b00};
    d0 = done_ev;
    do_frame(din, 16, st, bs, da);
    model_end(din, 16);
    checks++; if (st[17:2] !== exp_s[17:2]) begin errors++; $display("FAIL recov_dout got %h want %h", st[17:2], exp_s[17:2]); end
    checks++; if (done_ev - d0 !== 1 || ctrlWord !== m_ctrl || curAddr !== m_addr) begin
      errors++; $display("FAIL recov_regs done %0d ctrl %h addr %0d want 1 %h %0d", done_ev - d0, ctrlWord, curAddr, m_ctrl, m_addr);
    end
  endtask

  task automatic test_idle_clocks();
    logic [17:0] st; logic bs, da; logic [15:0] din; int d0, e0;
    d0 = done_ev; e0 = err_ev;
    spi.DIN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_clks(HALF); spi.SCLK = 1'b1; wait_clks(HALF); spi.SCLK = 1'b0;
    end
    spi.DIN = 1'b0;
    wait_clks(HALF);
    checks++; if (busy !== 1'b0 || done_ev != d0 || err_ev != e0) begin
      errors++; $display("FAIL idle_sclk busy %b done %0d err %0d want 0 0 0", busy, done_ev - d0, err_ev - e0);
    end
    din = 16'($urandom) | 16'h8000;
    do_frame(din, 16, st, bs, da);
    model_end(din, 16);
    checks++; if (ctrlWord !== m_ctrl) begin errors++; $display("FAIL idle_next_ctrl got %h want %h", ctrlWord, m_ctrl); end
  endtask

  task automatic test_random();
    logic [17:0] st, exp_s, mask; logic bs, da; logic [15:0] din;
    int n, sel, d0, e0, exp_d, exp_e;
    for (int k = 0; k < 16; k++) begin
      sampleData = {$urandom, $urandom, $urandom};
      din = 16'($urandom);
      if ($urandom_range(0, 2) != 0) din[15] = 1'b1;
      sel = $urandom_range(0, 5);
      n = (sel == 0) ? 0 : (sel < 3) ? $urandom_range(1, 15) : $urandom_range(16, 18);
      exp_s = {model_frame(sampleData, m_addr, m_coding), 2'b00};
      mask = '0;
      for (int i = 0; i < n && i < 18; i++) mask[17-i] = 1'b1;
      exp_d = (n >= 16) ? 1 : 0;
      exp_e = (n >= 1 && n <= 15) ? 1 : 0;
      d0 = done_ev; e0 = err_ev;
      do_frame(din, n, st, bs, da);
      model_end(din, n);
      if (n > 0) begin
        checks++; if ((st & mask) !== (exp_s & mask)) begin
          errors++; $display("FAIL rnd%0d_dout n=%0d got %h want %h", k, n, st & mask, exp_s & mask);
        end
      end
      checks++; if (done_ev - d0 !== exp_d || err_ev - e0 !== exp_e) begin
        errors++; $display("FAIL rnd%0d_pulses n=%0d done %0d err %0d want %0d %0d", k, n, done_ev - d0, err_ev - e0, exp_d, exp_e);
      end
      checks++; if (ctrlWord !== m_ctrl || curAddr !== m_addr) begin
        errors++; $display("FAIL rnd%0d_regs ctrl %h addr %0d want %h %0d", k, ctrlWord, curAddr, m_ctrl, m_addr);
      end
      checks++; if (da !== 1'b0) begin errors++; $display("FAIL rnd%0d_dout_idle got %b want 0", k, da); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [17:0] st; logic bs, da; logic [15:0] exp_f; int d0, e0;
    d0 = done_ev; e0 = err_ev;
    spi.CSN = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 7; i++) begin
      spi.DIN = 1'($urandom);
      wait_clks(HALF); spi.SCLK = 1'b1; wait_clks(HALF); spi.SCLK = 1'b0;
    end
    wait_clks(3);
    reset = 1'b1;
    wait_clks(3);
    checks++; if (ctrlWord !== 12'h000 || curAddr !== 3'd0) begin
      errors++; $display("FAIL midrst_regs ctrl %h addr %0d want 000 0", ctrlWord, curAddr);
    end
    checks++; if ({spi.DOUT, busy, frameDone, frameErr} !== 4'b0000) begin
      errors++; $display("FAIL midrst_flags got %b want 0000", {spi.DOUT, busy, frameDone, frameErr});
    end
    reset = 1'b0;
    m_ctrl = '0; m_addr = '0; m_coding = 1'b0;
    wait_clks(HALF);
    spi.CSN = 1'b1;
    spi.DIN = 1'b0;
    wait_clks(HALF);
    checks++; if (done_ev != d0 || err_ev != e0) begin
      errors++; $display("FAIL midrst_pulse done %0d err %0d want 0 0", done_ev - d0, err_ev - e0);
    end
    // Reset coding is two's complement on channel 0.
    sampleData = {$urandom, $urandom, $urandom};
    exp_f = model_frame(sampleData, m_addr, m_coding);
    do_frame(16'h0000, 16, st, bs, da);
    checks++; if (st[17:2] !== exp_f) begin errors++; $display("FAIL midrst_next_dout got %h want %h", st[17:2], exp_f); end
  endtask

  initial begin
    spi.SCLK   = 1'b0;
    spi.CSN    = 1'b1;
    spi.DIN    = 1'b0;
    sampleData = '0;
    m_ctrl     = '0;
    m_addr     = '0;
    m_coding   = 1'b0;

    test_reset();
    test_write_frame();
    test_coding();
    test_no_write();
    test_abort();
    test_idle_clocks();
    test_random();
    test_reset_mid_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_adc_spi_responder
